// File: rtl/kf_frame_sequencer_pkg.sv
// Shared fixed-point widths, Kalman core frame timing and the frame sequencer state encoding.
package kf_frame_sequencer_pkg;

  localparam int FXP_N        = 16;
  localparam int FXP_FRAC     = 12;
  localparam int KF_FRAME_CYC = 36;
  localparam int KF_DONE_LAT  = KF_FRAME_CYC + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_EMIT   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/kf_sample_fifo.sv
// Sample FIFO for the frame sequencer: wrap-bit pointers, full/empty from pointer compare.
module kf_sample_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push_valid,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A full FIFO refuses the push but still honours a pop in the same cycle.
  assign w_push = i_push_valid && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

  assign o_pop_data = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/kf_frame_sequencer.sv
// Feeds one (z,u) sample per Kalman core frame and returns X_post as next x_prev and as a result.
// Optional done watchdog: define KF_SEQ_WDOG_EN.
module kf_frame_sequencer
  import kf_frame_sequencer_pkg::*;
#(
  parameter int N        = FXP_N,
  parameter int FRAC     = FXP_FRAC,
  parameter int DEPTH    = 4,
  parameter int DONE_TMO = 40
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic signed [N-1:0] s_z00,
  input  logic signed [N-1:0] s_z10,
  input  logic signed [N-1:0] s_u00,
  input  logic signed [N-1:0] s_u10,
  input  logic                init_load,
  input  logic signed [N-1:0] x00_init,
  input  logic signed [N-1:0] x10_init,
  output logic                kf_start,
  output logic signed [N-1:0] kf_z00_meas,
  output logic signed [N-1:0] kf_z10_meas,
  output logic signed [N-1:0] kf_u00,
  output logic signed [N-1:0] kf_u10,
  output logic signed [N-1:0] kf_x00_prev,
  output logic signed [N-1:0] kf_x10_prev,
  input  logic                kf_done,
  input  logic signed [N-1:0] kf_X00_post,
  input  logic signed [N-1:0] kf_X10_post,
  output logic                m_valid,
  input  logic                m_ready,
  output logic signed [N-1:0] m_x00,
  output logic signed [N-1:0] m_x10,
  output logic                busy,
  output logic                err_tmo
);

  localparam int SW = 4 * N;

  seq_state_e          r_state;
  seq_state_e          w_state_nxt;
  logic                w_fifo_empty;
  logic                w_fifo_full;
  logic [SW-1:0]       w_head;
  logic                w_pop;
  logic                w_load_init;
  logic                w_capture;
  logic                w_timeout;
  logic                w_err;
  logic signed [N-1:0] r_z00, r_z10, r_u00, r_u10;
  logic signed [N-1:0] r_x00, r_x10;
  logic signed [N-1:0] r_m00, r_m10;
  logic                w_unused;

  assign w_unused = ^{FRAC[0], DONE_TMO[0]};

  kf_sample_fifo #(
    .WIDTH (SW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push_valid (s_valid),
    .i_push_data  ({s_z00, s_z10, s_u00, s_u10}),
    .i_pop        (w_pop),
    .o_pop_data   (w_head),
    .o_empty      (w_fifo_empty),
    .o_full       (w_fifo_full)
  );

  assign s_ready = !w_fifo_full;

`ifdef KF_SEQ_WDOG_EN
  localparam int CW = $clog2(DONE_TMO + 1) + 1;

  logic [CW-1:0] r_wd_cnt;
  logic          r_err;

  // Counts cycles since kf_start; only meaningful while in WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd_cnt <= '0;
    end else if (r_state == ST_LAUNCH) begin
      r_wd_cnt <= CW'(1);
    end else if (r_state == ST_WAIT) begin
      r_wd_cnt <= r_wd_cnt + CW'(1);
    end
  end

  assign w_timeout = (r_state == ST_WAIT) && !kf_done && (r_wd_cnt >= CW'(DONE_TMO));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_err <= 1'b0;
    else if (w_timeout) r_err <= 1'b1;
  end

  assign w_err = r_err;
`else
  assign w_timeout = 1'b0;
  assign w_err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // init_load wins over a pending launch, deferring it by one cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load_init = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (init_load) begin
          w_load_init = 1'b1;
        end else if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_LAUNCH;
        end
      end
      ST_LAUNCH: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (kf_done) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_EMIT;
        end else if (w_timeout) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_EMIT: begin
        if (m_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_z00 <= '0;
      r_z10 <= '0;
      r_u00 <= '0;
      r_u10 <= '0;
      r_x00 <= '0;
      r_x10 <= '0;
      r_m00 <= '0;
      r_m10 <= '0;
    end else begin
      if (w_pop) {r_z00, r_z10, r_u00, r_u10} <= w_head;
      if (w_load_init) begin
        r_x00 <= x00_init;
        r_x10 <= x10_init;
      end else if (w_capture) begin
        r_x00 <= kf_X00_post;
        r_x10 <= kf_X10_post;
      end
      if (w_capture) begin
        r_m00 <= kf_X00_post;
        r_m10 <= kf_X10_post;
      end
    end
  end

  assign kf_start    = (r_state == ST_LAUNCH);
  assign kf_z00_meas = r_z00;
  assign kf_z10_meas = r_z10;
  assign kf_u00      = r_u00;
  assign kf_u10      = r_u10;
  assign kf_x00_prev = r_x00;
  assign kf_x10_prev = r_x10;
  assign m_valid     = (r_state == ST_EMIT);
  assign m_x00       = r_m00;
  assign m_x10       = r_m10;
  assign busy        = (r_state != ST_IDLE);
  assign err_tmo     = w_err;

endmodule

// File: tb/tb_kf_frame_sequencer.sv
// Bench for kf_frame_sequencer: acts as the Kalman core and checks against a sample/result scoreboard.
`timescale 1ns/1ps
module tb_kf_frame_sequencer;
  import kf_frame_sequencer_pkg::*;

  localparam int N     = FXP_N;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [N-1:0] s_z00 = '0, s_z10 = '0, s_u00 = '0, s_u10 = '0;
  logic         init_load = 1'b0;
  logic [N-1:0] x00_init = '0, x10_init = '0;
  logic         kf_start;
  logic [N-1:0] kf_z00_meas, kf_z10_meas, kf_u00, kf_u10, kf_x00_prev, kf_x10_prev;
  logic         kf_done = 1'b0;
  logic [N-1:0] kf_X00_post = '0, kf_X10_post = '0;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [N-1:0] m_x00, m_x10;
  logic         busy;
  logic         err_tmo;

  kf_frame_sequencer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_z00(s_z00), .s_z10(s_z10), .s_u00(s_u00), .s_u10(s_u10),
    .init_load(init_load), .x00_init(x00_init), .x10_init(x10_init),
    .kf_start(kf_start),
    .kf_z00_meas(kf_z00_meas), .kf_z10_meas(kf_z10_meas), .kf_u00(kf_u00), .kf_u10(kf_u10),
    .kf_x00_prev(kf_x00_prev), .kf_x10_prev(kf_x10_prev),
    .kf_done(kf_done), .kf_X00_post(kf_X00_post), .kf_X10_post(kf_X10_post),
    .m_valid(m_valid), .m_ready(m_ready), .m_x00(m_x00), .m_x10(m_x10),
    .busy(busy), .err_tmo(err_tmo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [4*N-1:0] smp_q[$];
  logic [2*N-1:0] res_q[$];
  logic [2*N-1:0] post_ovr[$];
  logic [2*N-1:0] x_m = '0;
  logic [6*N-1:0] launch_v = '0;
  bit             core_armed = 0;
  bit             core_hold = 0;
  int             core_cnt = 0;
  int             last_start = -1;
  int             gaps[$];
  int             n_starts = 0, n_results = 0, n_acc = 0, push_cyc = 0;
  bit             stim_valid = 0, stim_init = 0, mr_stim = 1;
  logic [4*N-1:0] stim_data = '0;
  logic [2*N-1:0] stim_x = '0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: observe this cycle's outputs, play the core, then drive this cycle's inputs.
  task automatic tick();
    logic [2*N-1:0] post;
    @(negedge clk);
    cyc++;
    if (kf_start === 1'b1) begin
      check("start_idle", core_armed || (res_q.size() != 0), 0);
      check("start_has_sample", smp_q.size() != 0, 1);
      if (smp_q.size() != 0)
        check("launch_sample", {kf_z00_meas, kf_z10_meas, kf_u00, kf_u10}, smp_q.pop_front());
      check("launch_xprev", {kf_x00_prev, kf_x10_prev}, x_m);
      if (last_start >= 0) gaps.push_back(cyc - last_start);
      last_start = cyc;
      n_starts++;
      launch_v = {kf_z00_meas, kf_z10_meas, kf_u00, kf_u10, kf_x00_prev, kf_x10_prev};
      core_armed = 1;
      core_cnt = 0;
    end else if (core_armed) begin
      core_cnt++;
      check("frame_inputs_held",
            {kf_z00_meas, kf_z10_meas, kf_u00, kf_u10, kf_x00_prev, kf_x10_prev}, launch_v);
    end
    check("s_ready", s_ready, smp_q.size() < DEPTH);
    check("m_valid", m_valid, res_q.size() != 0);
    if (m_valid === 1'b1 && res_q.size() != 0) check("m_x", {m_x00, m_x10}, res_q[0]);
    m_ready = mr_stim;
    if (m_valid === 1'b1 && mr_stim && res_q.size() != 0) begin
      void'(res_q.pop_front());
      n_results++;
    end
    kf_done = 1'b0;
    {kf_X00_post, kf_X10_post} = $urandom;
    if (core_armed && !core_hold && core_cnt == KF_DONE_LAT) begin
      if (post_ovr.size() != 0) post = post_ovr.pop_front();
      else                      post = $urandom;
      kf_done = 1'b1;
      {kf_X00_post, kf_X10_post} = post;
      res_q.push_back(post);
      x_m = post;
      core_armed = 0;
    end
    s_valid = stim_valid;
    {s_z00, s_z10, s_u00, s_u10} = stim_data;
    if (stim_valid && s_ready === 1'b1) begin
      smp_q.push_back(stim_data);
      stim_valid = 0;
      n_acc++;
      push_cyc = cyc;
    end
    init_load = stim_init;
    {x00_init, x10_init} = stim_x;
    stim_init = 0;
  endtask

  task automatic push_one(input logic [4*N-1:0] d);
    int k;
    stim_data = d;
    stim_valid = 1;
    k = 0;
    while (stim_valid && k < 200) begin tick(); k++; end
    check("push_accepted", stim_valid, 0);
    stim_valid = 0;
  endtask

  task automatic run_until_results(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (n_results < target && k < budget) begin tick(); k++; end
    check(tag, n_results >= target, 1);
  endtask

  initial begin
    int k, p, s0, r0, rel, idx, acc0;
    logic [4*N-1:0] samp [6];

    tick();
    tick();
    check("reset_ctrl", {kf_start, m_valid, busy, err_tmo}, 0);
    check("reset_frame_data", {kf_z00_meas, kf_z10_meas, kf_u00, kf_u10, kf_x00_prev, kf_x10_prev}, 0);
    check("reset_m_x", {m_x00, m_x10}, 0);
    check("reset_s_ready", s_ready, 1);
    rst_n = 1'b1;
    tick();

    // Single frame with known data
    push_one({16'h0100, 16'h0200, 16'h0000, 16'h0000});
    p = push_cyc;
    post_ovr.push_back(32'h0111_0222);
    k = 0;
    while (n_starts == 0 && k < 10) begin tick(); k++; end
    check("start_latency", last_start - p, 2);
    check("first_z00", kf_z00_meas, 16'h0100);
    k = 0;
    while (m_valid !== 1'b1 && k < 60) begin tick(); k++; end
    check("first_m_x", {m_x00, m_x10}, 32'h0111_0222);
    run_until_results(1, 60, "first_result");
    check("x_prev_feedback", {kf_x00_prev, kf_x10_prev}, 32'h0111_0222);

    // Six back-to-back samples into a depth-4 FIFO
    for (int i = 0; i < 6; i++) samp[i] = {$urandom, $urandom};
    gaps.delete();
    last_start = -1;
    s0 = n_starts;
    r0 = n_results;
    acc0 = n_acc;
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      if (!stim_valid && idx < 6) begin stim_data = samp[idx]; stim_valid = 1; idx++; end
      tick();
    end
    check("accepted_in_6_cycles", n_acc - acc0, 5);
    k = 0;
    while ((idx < 6 || stim_valid) && k < 400) begin
      if (!stim_valid && idx < 6) begin stim_data = samp[idx]; stim_valid = 1; idx++; end
      tick();
      k++;
    end
    check("stream_all_accepted", n_acc - acc0, 6);
    run_until_results(r0 + 6, 400, "stream_results");
    check("stream_frames", n_starts - s0, 6);
    check("stream_gap_count", gaps.size(), 5);
    foreach (gaps[i]) check("start_spacing", gaps[i], 40);

    // Downstream backpressure in EMIT
    mr_stim = 0;
    r0 = n_results;
    push_one({$urandom, $urandom});
    push_one({$urandom, $urandom});
    k = 0;
    while (m_valid !== 1'b1 && k < 80) begin tick(); k++; end
    s0 = n_starts;
    repeat (20) tick();
    check("no_start_in_emit", n_starts - s0, 0);
    check("m_valid_held", m_valid, 1);
    mr_stim = 1;
    tick();
    rel = cyc;
    k = 0;
    while (n_starts == s0 && k < 10) begin tick(); k++; end
    check("relaunch_after_accept", last_start - rel, 2);
    run_until_results(r0 + 2, 120, "backpressure_results");
    tick();

    // init_load collides with a launch; later init_load inside WAIT
    push_one({$urandom, $urandom});
    p = push_cyc;
    stim_init = 1;
    stim_x = 32'h7FFF_FFFF;
    x_m = 32'h7FFF_FFFF;
    s0 = n_starts;
    k = 0;
    while (n_starts == s0 && k < 10) begin tick(); k++; end
    check("init_defers_launch", last_start - p, 3);
    check("launch_uses_init", {kf_x00_prev, kf_x10_prev}, 32'h7FFF_FFFF);
    repeat (5) tick();
    stim_init = 1;
    stim_x = 32'h1234_5678;
    repeat (3) tick();
    check("init_ignored_in_wait", {kf_x00_prev, kf_x10_prev}, 32'h7FFF_FFFF);
    run_until_results(n_results + 1, 60, "init_frame_result");
    tick();

    // Reset in the middle of WAIT with a sample still queued
    push_one({$urandom, $urandom});
    push_one({$urandom, $urandom});
    k = 0;
    while (!(core_armed && core_cnt >= 10) && k < 60) begin tick(); k++; end
    rst_n = 1'b0;
    smp_q.delete();
    res_q.delete();
    post_ovr.delete();
    core_armed = 0;
    x_m = '0;
    stim_valid = 0;
    tick();
    check("rst_mid_ctrl", {kf_start, m_valid, busy, err_tmo}, 0);
    check("rst_mid_data", {kf_z00_meas, kf_z10_meas, kf_u00, kf_u10, kf_x00_prev, kf_x10_prev, m_x00, m_x10}, 0);
    check("rst_mid_s_ready", s_ready, 1);
    tick();
    rst_n = 1'b1;
    s0 = n_starts;
    repeat (60) tick();
    check("no_start_after_reset", n_starts - s0, 0);
    r0 = n_results;
    push_one({$urandom, $urandom});
    run_until_results(r0 + 1, 60, "post_reset_frame");

`ifdef KF_SEQ_WDOG_EN
    // Core never answers: watchdog drops the sample and the next one proceeds
    core_hold = 1;
    push_one({$urandom, $urandom});
    push_one({$urandom, $urandom});
    k = 0;
    while (err_tmo !== 1'b1 && k < 100) begin tick(); k++; end
    check("err_tmo_set", err_tmo, 1);
    check("idle_after_tmo", busy, 0);
    check("xprev_kept", {kf_x00_prev, kf_x10_prev}, x_m);
    core_armed = 0;
    core_hold = 0;
    r0 = n_results;
    run_until_results(r0 + 1, 100, "frame_after_tmo");
    check("err_tmo_sticky", err_tmo, 1);
`else
    check("err_tmo_off", err_tmo, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
